core_issue_sched: RTL

CORE_ISSUE_SCHED -- requirements
Module: core_issue_sched

---
 rtl/core_issue_sched_pkg.sv | 28 ++
 rtl/core_issue_scoreboard.sv | 75 +++++++
 rtl/core_issue_sched.sv | 86 ++++++++
 3 files changed

// File: rtl/core_issue_sched_pkg.sv
// Shared issue-stage definitions: latency-class codes, register-file geometry
// and the flat per-slot view the scheduler works on.
package core_issue_sched_pkg;

   localparam int NREG = 32;
   localparam int RW   = 5;

   // Latency classes carried with each instruction from decode.
   localparam logic [1:0] CLS_ALU  = 2'd0;
   localparam logic [1:0] CLS_LSU  = 2'd1;
   localparam logic [1:0] CLS_MUL  = 2'd2;
   localparam logic [1:0] CLS_LONG = 2'd3;

   // One issue slot, gathered from the flat frontend ports.
   typedef struct packed {
      logic                valid;
      logic [1:0][RW-1:0] src;
      logic [RW-1:0]       dst;
      logic [1:0]          cls;
      logic                single;
   } slot_t;

   // True when the slot reads a nonzero register r (RAW on r inside a pair).
   function automatic logic reads_reg(slot_t s, logic [RW-1:0] r);
      return (r != '0) && ((s.src[0] == r) || (s.src[1] == r));
   endfunction

endpackage

// File: rtl/core_issue_scoreboard.sv
// Register scoreboard: per-register 2-bit countdown plus a long-pending bit,
// four ready lookups, two issue update ports, one long writeback release port.
module core_issue_scoreboard
   import core_issue_sched_pkg::*;
#(
   parameter logic [1:0] LONG_CLASS = CLS_LONG
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0][RW-1:0]   i_rd_reg,
   output logic [3:0]           o_rd_ready,
   input  logic [1:0]           i_upd_en,
   input  logic [1:0][RW-1:0]   i_upd_reg,
   input  logic [1:0][1:0]      i_upd_cls,
   input  logic                 i_rel_en,
   input  logic [RW-1:0]        i_rel_reg,
   input  logic                 i_stall,
   input  logic                 i_flush,
   output logic                 o_long_busy
);

   logic [NREG-1:0][1:0] r_cnt;
   logic [NREG-1:0]      r_lp;
   logic                 r_long_busy;

   logic [1:0]           w_wr_en;
   logic                 w_long_set;

   // Ready lookup: register 0 is hardwired ready.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         o_rd_ready[i] = (i_rd_reg[i] == '0) ||
                         ((r_cnt[i_rd_reg[i]] == 2'd0) && !r_lp[i_rd_reg[i]]);
      end
   end

   // Younger slot wins when both slots target the same register; the long
   // unit still becomes occupied if the older slot started a LONG op.
   always_comb begin
      w_wr_en[1] = i_upd_en[1];
      w_wr_en[0] = i_upd_en[0] && !(i_upd_en[1] && (i_upd_reg[1] == i_upd_reg[0]));
      w_long_set = (i_upd_en[0] && (i_upd_cls[0] == LONG_CLASS)) ||
                   (i_upd_en[1] && (i_upd_cls[1] == LONG_CLASS));
   end

   // Scoreboard state: flush/reset clear everything; otherwise decrement,
   // then release, then issue loads (later assignments take priority).
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_cnt       <= '0;
         r_lp        <= '0;
         r_long_busy <= 1'b0;
      end else begin
         if (!i_stall) begin
            for (int r = 0; r < NREG; r++) begin
               if (r_cnt[r] != 2'd0) r_cnt[r] <= r_cnt[r] - 2'd1;
            end
         end
         if (i_rel_en) begin
            r_lp[i_rel_reg] <= 1'b0;
            r_long_busy     <= 1'b0;
         end
         if (w_long_set) r_long_busy <= 1'b1;
         for (int k = 0; k < 2; k++) begin
            if (w_wr_en[k]) begin
               if (i_upd_cls[k] == LONG_CLASS) r_lp[i_upd_reg[k]]  <= 1'b1;
               else                            r_cnt[i_upd_reg[k]] <= i_upd_cls[k];
            end
         end
      end
   end

   assign o_long_busy = r_long_busy;

endmodule

// File: rtl/core_issue_sched.sv
// Dual-slot in-order issue scheduler. Decides combinationally which of the two
// frontend slots issue this cycle against a registered register scoreboard.
module core_issue_sched
   import core_issue_sched_pkg::*;
#(
   parameter logic [1:0] LONG_CLASS = CLS_LONG
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            inst_valid_i,
   input  logic [1:0][1:0][4:0]  r_reg_i,
   input  logic [1:0][4:0]       w_reg_i,
   input  logic [1:0][1:0]       lat_class_i,
   input  logic [1:0]            single_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  long_done_i,
   input  logic [4:0]            long_done_reg_i,
   output logic [1:0]            issue_o,
   output logic [1:0]            ex_valid_o
);

   slot_t [1:0]         w_slot;
   logic  [3:0][RW-1:0] w_rd_reg;
   logic  [3:0]         w_rd_ready;
   logic                w_long_busy;
   logic  [1:0]         w_issue;
   logic  [1:0]         w_upd_en;
   logic  [1:0]         r_ex_valid;

   // Flat port fields gathered into slot records; no decoding here.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_slot[k].valid  = inst_valid_i[k];
         w_slot[k].src    = r_reg_i[k];
         w_slot[k].dst    = w_reg_i[k];
         w_slot[k].cls    = lat_class_i[k];
         w_slot[k].single = single_i[k];
      end
      w_rd_reg = {w_slot[1].src[1], w_slot[1].src[0],
                  w_slot[0].src[1], w_slot[0].src[0]};
   end

   core_issue_scoreboard #(.LONG_CLASS(LONG_CLASS)) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd_reg    (w_rd_reg),
      .o_rd_ready  (w_rd_ready),
      .i_upd_en    (w_upd_en),
      .i_upd_reg   ({w_slot[1].dst, w_slot[0].dst}),
      .i_upd_cls   ({w_slot[1].cls, w_slot[0].cls}),
      .i_rel_en    (long_done_i),
      .i_rel_reg   (long_done_reg_i),
      .i_stall     (stall_i),
      .i_flush     (flush_i),
      .o_long_busy (w_long_busy)
   );

   // Issue decision: slot 1 only pairs behind an issuing slot 0, so the mask
   // is always 00, 01 or 11.
   always_comb begin
      w_issue    = 2'b00;
      w_issue[0] = rst_n && w_slot[0].valid && !stall_i && !flush_i &&
                   w_rd_ready[0] && w_rd_ready[1] &&
                   ((w_slot[0].cls != LONG_CLASS) || !w_long_busy);
      w_issue[1] = w_issue[0] && w_slot[1].valid &&
                   !w_slot[0].single && !w_slot[1].single &&
                   w_rd_ready[2] && w_rd_ready[3] &&
                   !reads_reg(w_slot[1], w_slot[0].dst) &&
                   !((w_slot[0].cls != CLS_ALU) && (w_slot[1].cls != CLS_ALU));
      for (int k = 0; k < 2; k++) begin
         w_upd_en[k] = w_issue[k] && (w_slot[k].dst != '0);
      end
   end

   assign issue_o = w_issue;

   // Issued mask handed to execute one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) r_ex_valid <= 2'b00;
      else                   r_ex_valid <= w_issue;
   end

   assign ex_valid_o = r_ex_valid;

endmodule
